// File: rtl/ep2_pred_pkg.sv
// Shared types and constants for the predicate demux / branch blocks.
package ep2_pred_pkg;

  // Branch FSM: waiting for a packet head, or inside a multi-beat packet.
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pred_branch_state_t;

  // Predicate value that selects the true branch.
  localparam logic PRED_TRUE = 1'b1;

endpackage

// File: rtl/axis_fifo.sv
// Synchronous AXI-Stream FIFO (data only).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset (empties the FIFO)
//   s_axis_tdata_i/tvalid_i       write side payload and valid
//   s_axis_tready_o               not full, or a pop frees a slot this cycle
//   m_axis_tdata_o/tvalid_o       head of queue and non-empty flag
//   m_axis_tready_i               pop the head
module axis_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  always_comb begin
    empty           = (wr_ptr_q == rd_ptr_q);
    full            = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    m_axis_tvalid_o = !empty;
    m_axis_tdata_o  = mem_q[rd_ptr_q[AW-1:0]];
    pop             = !empty && m_axis_tready_i;
    // A pop frees the head slot, so a full FIFO can still accept in the same cycle.
    s_axis_tready_o = !full || pop;
    push            = s_axis_tvalid_i && s_axis_tready_o;
    wr_ptr_d        = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d        = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; contents are don't-care while the pointers mark them empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata_i;
    end
  end

endmodule

// File: rtl/pred_branch.sv
// Joins a 1-bit predicate stream with a payload stream and routes each item
// (beat, or packet when IF_STREAM=1) to the true or false output; the false
// branch may discard instead. Both outputs are 1-entry registered slots.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   s_pred_tdata/tvalid/tready        predicate input (1 = true branch), FIFO buffered
//   s_data_tdata/tlast/tvalid/tready  payload input
//   m_true_*                          true-branch payload output
//   m_false_*                         false-branch payload output (idle when DROP_FALSE=1)
//   cnt_true, cnt_false               saturating item counters
module pred_branch
  import ep2_pred_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned IF_STREAM      = 0,
  parameter int unsigned DROP_FALSE     = 0,
  parameter int unsigned PRED_FIFO_SIZE = 16,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_pred_tdata,
  input  logic                  s_pred_tvalid,
  output logic                  s_pred_tready,
  input  logic [DATA_WIDTH-1:0] s_data_tdata,
  input  logic                  s_data_tlast,
  input  logic                  s_data_tvalid,
  output logic                  s_data_tready,
  output logic [DATA_WIDTH-1:0] m_true_tdata,
  output logic                  m_true_tlast,
  output logic                  m_true_tvalid,
  input  logic                  m_true_tready,
  output logic [DATA_WIDTH-1:0] m_false_tdata,
  output logic                  m_false_tlast,
  output logic                  m_false_tvalid,
  input  logic                  m_false_tready,
  output logic [CNT_WIDTH-1:0]  cnt_true,
  output logic [CNT_WIDTH-1:0]  cnt_false
);

  localparam bit STREAM = (IF_STREAM != 0);
  localparam bit DROP   = (DROP_FALSE != 0);

  pred_branch_state_t    state_q, state_d;
  logic                  pred_q, pred_d;

  logic                  true_valid_q, true_valid_d;
  logic [DATA_WIDTH-1:0] true_data_q, true_data_d;
  logic                  true_last_q, true_last_d;
  logic                  false_valid_q, false_valid_d;
  logic [DATA_WIDTH-1:0] false_data_q, false_data_d;
  logic                  false_last_q, false_last_d;
  logic [CNT_WIDTH-1:0]  cnt_true_q, cnt_true_d;
  logic [CNT_WIDTH-1:0]  cnt_false_q, cnt_false_d;

  logic                  fifo_head;
  logic                  fifo_valid;
  logic                  fifo_pop;
  logic                  in_pkt;
  logic                  pred_avail;
  logic                  sel;
  logic                  can_true;
  logic                  can_false;
  logic                  data_ready;
  logic                  xfer;
  logic                  beat_last;

  // Predicate queue.
  axis_fifo #(
    .DATA_WIDTH (1),
    .DEPTH      (PRED_FIFO_SIZE)
  ) u_pred_fifo (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata_i  (s_pred_tdata),
    .s_axis_tvalid_i (s_pred_tvalid),
    .s_axis_tready_o (s_pred_tready),
    .m_axis_tdata_o  (fifo_head),
    .m_axis_tvalid_o (fifo_valid),
    .m_axis_tready_i (fifo_pop)
  );

  // Predicate selection and input handshake.
  always_comb begin
    in_pkt     = (state_q == IN_PKT);
    pred_avail = in_pkt || fifo_valid;
    sel        = in_pkt ? pred_q : fifo_head;
    can_true   = !true_valid_q || m_true_tready;
    can_false  = !false_valid_q || m_false_tready;
    // A dropping false branch never back-pressures.
    data_ready = pred_avail &&
                 ((sel == PRED_TRUE) ? can_true : (DROP || can_false));
    xfer       = s_data_tvalid && data_ready;
    beat_last  = STREAM ? s_data_tlast : 1'b1;
    // The head is consumed only by the first beat of an item.
    fifo_pop   = xfer && !in_pkt;
  end

  // Next state: FSM, output slots and counters.
  always_comb begin
    state_d       = state_q;
    pred_d        = pred_q;
    true_valid_d  = true_valid_q && !m_true_tready;
    true_data_d   = true_data_q;
    true_last_d   = true_last_q;
    false_valid_d = false_valid_q && !m_false_tready;
    false_data_d  = false_data_q;
    false_last_d  = false_last_q;
    cnt_true_d    = cnt_true_q;
    cnt_false_d   = cnt_false_q;

    case (state_q)
      IDLE: begin
        // Multi-beat packet: hold the popped predicate until tlast.
        if (STREAM && xfer && !s_data_tlast) begin
          state_d = IN_PKT;
          pred_d  = fifo_head;
        end
      end
      IN_PKT: begin
        if (xfer && s_data_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer && (sel == PRED_TRUE)) begin
      true_valid_d = 1'b1;
      true_data_d  = s_data_tdata;
      true_last_d  = beat_last;
    end

    if (xfer && (sel != PRED_TRUE) && !DROP) begin
      false_valid_d = 1'b1;
      false_data_d  = s_data_tdata;
      false_last_d  = beat_last;
    end

    // Saturating item counters.
    if (xfer && beat_last) begin
      if (sel == PRED_TRUE) begin
        if (cnt_true_q != {CNT_WIDTH{1'b1}}) begin
          cnt_true_d = cnt_true_q + CNT_WIDTH'(1);
        end
      end else begin
        if (cnt_false_q != {CNT_WIDTH{1'b1}}) begin
          cnt_false_d = cnt_false_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pred_q        <= 1'b0;
      true_valid_q  <= 1'b0;
      true_data_q   <= '0;
      true_last_q   <= 1'b0;
      false_valid_q <= 1'b0;
      false_data_q  <= '0;
      false_last_q  <= 1'b0;
      cnt_true_q    <= '0;
      cnt_false_q   <= '0;
    end else begin
      state_q       <= state_d;
      pred_q        <= pred_d;
      true_valid_q  <= true_valid_d;
      true_data_q   <= true_data_d;
      true_last_q   <= true_last_d;
      false_valid_q <= false_valid_d;
      false_data_q  <= false_data_d;
      false_last_q  <= false_last_d;
      cnt_true_q    <= cnt_true_d;
      cnt_false_q   <= cnt_false_d;
    end
  end

  assign s_data_tready  = data_ready;
  assign m_true_tdata   = true_data_q;
  assign m_true_tlast   = true_last_q;
  assign m_true_tvalid  = true_valid_q;
  assign m_false_tdata  = false_data_q;
  assign m_false_tlast  = false_last_q;
  assign m_false_tvalid = false_valid_q;
  assign cnt_true       = cnt_true_q;
  assign cnt_false      = cnt_false_q;

endmodule

// File: tb/tb_pred_branch.sv
// Directed bench for pred_branch: beat mode (a_), packet mode (b_), drop-false beat mode (c_).
module tb_pred_branch;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic          a_pred, a_pred_v, a_pred_r, a_dl, a_dv, a_dr;
  logic [DW-1:0] a_d, a_t_d, a_f_d;
  logic          a_t_l, a_t_v, a_t_r, a_f_l, a_f_v, a_f_r;
  logic [CW-1:0] a_ct, a_cf;

  logic          b_pred, b_pred_v, b_pred_r, b_dl, b_dv, b_dr;
  logic [DW-1:0] b_d, b_t_d, b_f_d;
  logic          b_t_l, b_t_v, b_t_r, b_f_l, b_f_v, b_f_r;
  logic [CW-1:0] b_ct, b_cf;

  logic          c_pred, c_pred_v, c_pred_r, c_dl, c_dv, c_dr;
  logic [DW-1:0] c_d, c_t_d, c_f_d;
  logic          c_t_l, c_t_v, c_t_r, c_f_l, c_f_v, c_f_r;
  logic [CW-1:0] c_ct, c_cf;

  pred_branch #(.DATA_WIDTH(DW), .IF_STREAM(0), .DROP_FALSE(0), .PRED_FIFO_SIZE(16), .CNT_WIDTH(CW)) u_a (
    .clk(clk), .rst(rst),
    .s_pred_tdata(a_pred), .s_pred_tvalid(a_pred_v), .s_pred_tready(a_pred_r),
    .s_data_tdata(a_d), .s_data_tlast(a_dl), .s_data_tvalid(a_dv), .s_data_tready(a_dr),
    .m_true_tdata(a_t_d), .m_true_tlast(a_t_l), .m_true_tvalid(a_t_v), .m_true_tready(a_t_r),
    .m_false_tdata(a_f_d), .m_false_tlast(a_f_l), .m_false_tvalid(a_f_v), .m_false_tready(a_f_r),
    .cnt_true(a_ct), .cnt_false(a_cf));

  pred_branch #(.DATA_WIDTH(DW), .IF_STREAM(1), .DROP_FALSE(0), .PRED_FIFO_SIZE(16), .CNT_WIDTH(CW)) u_b (
    .clk(clk), .rst(rst),
    .s_pred_tdata(b_pred), .s_pred_tvalid(b_pred_v), .s_pred_tready(b_pred_r),
    .s_data_tdata(b_d), .s_data_tlast(b_dl), .s_data_tvalid(b_dv), .s_data_tready(b_dr),
    .m_true_tdata(b_t_d), .m_true_tlast(b_t_l), .m_true_tvalid(b_t_v), .m_true_tready(b_t_r),
    .m_false_tdata(b_f_d), .m_false_tlast(b_f_l), .m_false_tvalid(b_f_v), .m_false_tready(b_f_r),
    .cnt_true(b_ct), .cnt_false(b_cf));

  pred_branch #(.DATA_WIDTH(DW), .IF_STREAM(0), .DROP_FALSE(1), .PRED_FIFO_SIZE(16), .CNT_WIDTH(CW)) u_c (
    .clk(clk), .rst(rst),
    .s_pred_tdata(c_pred), .s_pred_tvalid(c_pred_v), .s_pred_tready(c_pred_r),
    .s_data_tdata(c_d), .s_data_tlast(c_dl), .s_data_tvalid(c_dv), .s_data_tready(c_dr),
    .m_true_tdata(c_t_d), .m_true_tlast(c_t_l), .m_true_tvalid(c_t_v), .m_true_tready(c_t_r),
    .m_false_tdata(c_f_d), .m_false_tlast(c_f_l), .m_false_tvalid(c_f_v), .m_false_tready(c_f_r),
    .cnt_true(c_ct), .cnt_false(c_cf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    total++; if (a_t_v !== 1'b0) begin bad++; $display("FAIL rst_a_tv: got %0h exp 0", a_t_v); end
    total++; if (a_f_v !== 1'b0) begin bad++; $display("FAIL rst_a_fv: got %0h exp 0", a_f_v); end
    total++; if (b_t_v !== 1'b0) begin bad++; $display("FAIL rst_b_tv: got %0h exp 0", b_t_v); end
    total++; if (b_f_v !== 1'b0) begin bad++; $display("FAIL rst_b_fv: got %0h exp 0", b_f_v); end
    total++; if (c_t_v !== 1'b0) begin bad++; $display("FAIL rst_c_tv: got %0h exp 0", c_t_v); end
    total++; if (a_ct !== 8'd0) begin bad++; $display("FAIL rst_a_ct: got %0d exp 0", a_ct); end
    total++; if (a_cf !== 8'd0) begin bad++; $display("FAIL rst_a_cf: got %0d exp 0", a_cf); end
    total++; if (b_t_d !== 16'h0) begin bad++; $display("FAIL rst_b_td: got %0h exp 0", b_t_d); end
    total++; if (a_dr !== 1'b0) begin bad++; $display("FAIL rst_a_dr: got %0h exp 0", a_dr); end
    total++; if (a_pred_r !== 1'b1) begin bad++; $display("FAIL rst_a_pr: got %0h exp 1", a_pred_r); end
    tick();
    rst = 1'b0;
  endtask

  // Beat mode: preds 1,0,1 with data A,B,C.
  task automatic test_beat_routing();
    logic [2:0] preds;
    preds = 3'b101;
    a_t_r = 1'b1; a_f_r = 1'b1;
    for (int i = 0; i < 3; i++) begin a_pred = preds[i]; a_pred_v = 1'b1; tick(); end
    a_pred_v = 1'b0;
    a_d = 16'h000A; a_dv = 1'b1; #1;
    total++; if (a_dr !== 1'b1) begin bad++; $display("FAIL rt_dr: got %0h exp 1", a_dr); end
    tick();
    total++; if (a_t_v !== 1'b1 || a_t_d !== 16'h000A) begin bad++; $display("FAIL rt_A: got v=%0h d=%0h exp v=1 d=a", a_t_v, a_t_d); end
    total++; if (a_t_l !== 1'b1) begin bad++; $display("FAIL rt_A_last: got %0h exp 1", a_t_l); end
    total++; if (a_f_v !== 1'b0) begin bad++; $display("FAIL rt_A_fv: got %0h exp 0", a_f_v); end
    a_d = 16'h000B; tick();
    total++; if (a_f_v !== 1'b1 || a_f_d !== 16'h000B) begin bad++; $display("FAIL rt_B: got v=%0h d=%0h exp v=1 d=b", a_f_v, a_f_d); end
    total++; if (a_t_v !== 1'b0) begin bad++; $display("FAIL rt_B_tv: got %0h exp 0", a_t_v); end
    a_d = 16'h000C; tick();
    total++; if (a_t_v !== 1'b1 || a_t_d !== 16'h000C) begin bad++; $display("FAIL rt_C: got v=%0h d=%0h exp v=1 d=c", a_t_v, a_t_d); end
    total++; if (a_f_v !== 1'b0) begin bad++; $display("FAIL rt_C_fv: got %0h exp 0", a_f_v); end
    a_dv = 1'b0; tick();
    total++; if (a_t_v !== 1'b0) begin bad++; $display("FAIL rt_drain: got %0h exp 0", a_t_v); end
    total++; if (a_ct !== 8'd2 || a_cf !== 8'd1) begin bad++; $display("FAIL rt_cnt: got t=%0d f=%0d exp t=2 f=1", a_ct, a_cf); end
  endtask

  // No predicate queued: payload must stall.
  task automatic test_starvation();
    a_d = 16'h0099; a_dv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_dr !== 1'b0) begin bad++; $display("FAIL starve_dr%0d: got %0h exp 0", i, a_dr); end
      tick();
    end
    a_dv = 1'b0;
  endtask

  task automatic test_backpressure();
    a_t_r = 1'b0;
    a_pred = 1'b1; a_pred_v = 1'b1; tick(); tick(); a_pred_v = 1'b0;
    a_d = 16'h0031; a_dv = 1'b1; #1;
    total++; if (a_dr !== 1'b1) begin bad++; $display("FAIL bp_dr1: got %0h exp 1", a_dr); end
    tick();
    total++; if (a_t_v !== 1'b1 || a_t_d !== 16'h0031) begin bad++; $display("FAIL bp_first: got v=%0h d=%0h exp v=1 d=31", a_t_v, a_t_d); end
    a_d = 16'h0032; #1;
    total++; if (a_dr !== 1'b0) begin bad++; $display("FAIL bp_dr2: got %0h exp 0", a_dr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (a_t_v !== 1'b1 || a_t_d !== 16'h0031 || a_dr !== 1'b0) begin bad++; $display("FAIL bp_hold%0d: got v=%0h d=%0h r=%0h exp v=1 d=31 r=0", i, a_t_v, a_t_d, a_dr); end
    end
    a_t_r = 1'b1; #1;
    total++; if (a_dr !== 1'b1) begin bad++; $display("FAIL bp_release: got %0h exp 1", a_dr); end
    tick();
    total++; if (a_t_v !== 1'b1 || a_t_d !== 16'h0032) begin bad++; $display("FAIL bp_second: got v=%0h d=%0h exp v=1 d=32", a_t_v, a_t_d); end
    a_dv = 1'b0; tick();
    total++; if (a_t_v !== 1'b0) begin bad++; $display("FAIL bp_drain: got %0h exp 0", a_t_v); end
    total++; if (a_ct !== 8'd4) begin bad++; $display("FAIL bp_cnt: got %0d exp 4", a_ct); end
  endtask

  // Fill the 16-deep queue, push+pop while full, then drain all 16.
  task automatic test_fifo_full();
    a_pred = 1'b0; a_pred_v = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (a_pred_r !== 1'b1) begin bad++; $display("FAIL full_pr%0d: got %0h exp 1", i, a_pred_r); end
      tick();
    end
    total++; if (a_pred_r !== 1'b0) begin bad++; $display("FAIL full_pr16: got %0h exp 0", a_pred_r); end
    a_d = 16'h0040; a_dv = 1'b1; #1;
    total++; if (a_pred_r !== 1'b1 || a_dr !== 1'b1) begin bad++; $display("FAIL full_pushpop: got pr=%0h dr=%0h exp 1 1", a_pred_r, a_dr); end
    tick();
    total++; if (a_f_v !== 1'b1 || a_f_d !== 16'h0040) begin bad++; $display("FAIL full_pop: got v=%0h d=%0h exp v=1 d=40", a_f_v, a_f_d); end
    a_dv = 1'b0; #1;
    total++; if (a_pred_r !== 1'b0) begin bad++; $display("FAIL full_still: got %0h exp 0", a_pred_r); end
    a_pred_v = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_d = 16'h0100 + 16'(i); a_dv = 1'b1; #1;
      total++; if (a_dr !== 1'b1) begin bad++; $display("FAIL drain_dr%0d: got %0h exp 1", i, a_dr); end
      tick();
      total++; if (a_f_v !== 1'b1 || a_f_d !== 16'h0100 + 16'(i)) begin bad++; $display("FAIL drain_d%0d: got v=%0h d=%0h exp v=1 d=%0h", i, a_f_v, a_f_d, 16'h0100 + 16'(i)); end
    end
    a_dv = 1'b0; #1;
    total++; if (a_dr !== 1'b0) begin bad++; $display("FAIL drain_empty: got %0h exp 0", a_dr); end
    tick();
    total++; if (a_cf !== 8'd18) begin bad++; $display("FAIL drain_cnt: got %0d exp 18", a_cf); end
  endtask

  // Packet mode: pred 0 for a 3-beat packet, pred 1 for a 1-beat packet.
  task automatic test_packet();
    logic [DW-1:0] dat [4];
    logic [3:0]    lst;
    logic [3:0]    br;
    dat[0] = 16'h0010; dat[1] = 16'h0011; dat[2] = 16'h0012; dat[3] = 16'h0020;
    lst = 4'b1100; br = 4'b1000;
    b_t_r = 1'b1; b_f_r = 1'b1;
    b_pred = 1'b0; b_pred_v = 1'b1; tick();
    b_pred = 1'b1; tick();
    b_pred_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_d = dat[i]; b_dl = lst[i]; b_dv = 1'b1; #1;
      total++; if (b_dr !== 1'b1) begin bad++; $display("FAIL pkt_dr%0d: got %0h exp 1", i, b_dr); end
      tick();
      if (br[i]) begin
        total++; if (b_t_v !== 1'b1 || b_t_d !== dat[i] || b_t_l !== lst[i] || b_f_v !== 1'b0) begin bad++; $display("FAIL pkt_true%0d: got v=%0h d=%0h l=%0h fv=%0h exp v=1 d=%0h l=%0h fv=0", i, b_t_v, b_t_d, b_t_l, b_f_v, dat[i], lst[i]); end
      end else begin
        total++; if (b_f_v !== 1'b1 || b_f_d !== dat[i] || b_f_l !== lst[i] || b_t_v !== 1'b0) begin bad++; $display("FAIL pkt_false%0d: got v=%0h d=%0h l=%0h tv=%0h exp v=1 d=%0h l=%0h tv=0", i, b_f_v, b_f_d, b_f_l, b_t_v, dat[i], lst[i]); end
      end
    end
    b_dv = 1'b0; b_dl = 1'b0; #1;
    total++; if (b_dr !== 1'b0) begin bad++; $display("FAIL pkt_empty: got %0h exp 0", b_dr); end
    tick();
    total++; if (b_ct !== 8'd1 || b_cf !== 8'd1) begin bad++; $display("FAIL pkt_cnt: got t=%0d f=%0d exp t=1 f=1", b_ct, b_cf); end
  endtask

  // Drop-false: preds 0,0,1 with data 1,2,3 while m_false is not ready.
  task automatic test_drop();
    logic [2:0] preds;
    preds = 3'b100;
    c_t_r = 1'b1; c_f_r = 1'b0;
    for (int i = 0; i < 3; i++) begin c_pred = preds[i]; c_pred_v = 1'b1; tick(); end
    c_pred_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      c_d = 16'(i + 1); c_dv = 1'b1; #1;
      total++; if (c_dr !== 1'b1) begin bad++; $display("FAIL drop_dr%0d: got %0h exp 1", i, c_dr); end
      tick();
      total++; if (c_f_v !== 1'b0) begin bad++; $display("FAIL drop_fv%0d: got %0h exp 0", i, c_f_v); end
      if (i == 2) begin
        total++; if (c_t_v !== 1'b1 || c_t_d !== 16'h0003) begin bad++; $display("FAIL drop_true: got v=%0h d=%0h exp v=1 d=3", c_t_v, c_t_d); end
      end else begin
        total++; if (c_t_v !== 1'b0) begin bad++; $display("FAIL drop_tv%0d: got %0h exp 0", i, c_t_v); end
      end
    end
    c_dv = 1'b0; tick();
    total++; if (c_cf !== 8'd2 || c_ct !== 8'd1 || c_f_v !== 1'b0) begin bad++; $display("FAIL drop_cnt: got f=%0d t=%0d fv=%0h exp f=2 t=1 fv=0", c_cf, c_ct, c_f_v); end
  endtask

  // Reset after beat 2 of a 4-beat packet, then a fresh packet.
  task automatic test_reset_mid_packet();
    b_t_r = 1'b1; b_f_r = 1'b1;
    b_pred = 1'b1; b_pred_v = 1'b1; tick();
    b_pred = 1'b0; tick();
    b_pred_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b_d = 16'h0050 + 16'(i); b_dl = 1'b0; b_dv = 1'b1;
      tick();
      total++; if (b_t_v !== 1'b1 || b_t_d !== 16'h0050 + 16'(i)) begin bad++; $display("FAIL mid_beat%0d: got v=%0h d=%0h exp v=1 d=%0h", i, b_t_v, b_t_d, 16'h0050 + 16'(i)); end
    end
    rst = 1'b1; b_dv = 1'b0; #1;
    total++; if (b_t_v !== 1'b0 || b_f_v !== 1'b0 || b_t_d !== 16'h0) begin bad++; $display("FAIL mid_rst_out: got tv=%0h fv=%0h td=%0h exp 0 0 0", b_t_v, b_f_v, b_t_d); end
    total++; if (b_ct !== 8'd0 || b_cf !== 8'd0) begin bad++; $display("FAIL mid_rst_cnt: got t=%0d f=%0d exp 0 0", b_ct, b_cf); end
    tick();
    rst = 1'b0; b_dv = 1'b1; b_d = 16'h0053; #1;
    total++; if (b_dr !== 1'b0) begin bad++; $display("FAIL mid_idle_empty: got %0h exp 0", b_dr); end
    b_dv = 1'b0;
    b_pred = 1'b0; b_pred_v = 1'b1; tick();
    b_pred_v = 1'b0;
    b_d = 16'h0060; b_dl = 1'b1; b_dv = 1'b1; #1;
    total++; if (b_dr !== 1'b1) begin bad++; $display("FAIL mid_fresh_dr: got %0h exp 1", b_dr); end
    tick();
    total++; if (b_f_v !== 1'b1 || b_f_d !== 16'h0060 || b_f_l !== 1'b1 || b_t_v !== 1'b0) begin bad++; $display("FAIL mid_fresh: got v=%0h d=%0h l=%0h tv=%0h exp v=1 d=60 l=1 tv=0", b_f_v, b_f_d, b_f_l, b_t_v); end
    b_dv = 1'b0; b_dl = 1'b0; tick();
    total++; if (b_cf !== 8'd1 || b_ct !== 8'd0) begin bad++; $display("FAIL mid_fresh_cnt: got f=%0d t=%0d exp f=1 t=0", b_cf, b_ct); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    a_pred = 1'b0; a_pred_v = 1'b0; a_d = '0; a_dl = 1'b0; a_dv = 1'b0; a_t_r = 1'b0; a_f_r = 1'b0;
    b_pred = 1'b0; b_pred_v = 1'b0; b_d = '0; b_dl = 1'b0; b_dv = 1'b0; b_t_r = 1'b0; b_f_r = 1'b0;
    c_pred = 1'b0; c_pred_v = 1'b0; c_d = '0; c_dl = 1'b0; c_dv = 1'b0; c_t_r = 1'b0; c_f_r = 1'b0;
    test_reset();
    test_beat_routing();
    test_starvation();
    test_backpressure();
    test_fifo_full();
    test_packet();
    test_drop();
    test_reset_mid_packet();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
